mio_bus_ctrl: RTL and testbench

Memory/IO bus handshake unit directly downstream of the multicycle CPU controller. It consumes the controller's MemRead/MemWrite/CPU_MIO requests and the datapath's address and store data. It runs each access against a synchronous block RAM or the on-chip peripherals, returns load data, and pulses MIO_ready so the controller can leave its wait states.

---
 rtl/mio_bus_ctrl_if.sv | 21 ++
 rtl/mio_bus_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side memory/IO handshake bundle between the multicycle controller and mio_bus_ctrl.
interface mio_bus_ctrl_if;
    logic        mem_r;
    logic        mem_w;
    logic        cpu_mio;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mio_ready;
    logic        bus_err;

    modport master (
        output mem_r, mem_w, cpu_mio, addr, wdata,
        input  rdata, mio_ready, bus_err
    );

    modport slave (
        input  mem_r, mem_w, cpu_mio, addr, wdata,
        output rdata, mio_ready, bus_err
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus handshake unit: runs one access per controller request against a
// synchronous block RAM or on-chip peripherals and pulses mio_ready on completion.
module mio_bus_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int RAM_LAT = 1,
    parameter int LED_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    mio_bus_ctrl_if.slave     bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [LED_W-1:0]  led_out
);
    typedef enum logic [2:0] {S_IDLE, S_RAM_REQ, S_RAM_WAIT, S_IO_ACC, S_DONE} state_t;
    typedef enum logic [2:0] {R_RAM, R_LED, R_SW, R_CNT, R_NONE} region_t;

    localparam logic [2:0] WAIT_INIT = 3'(RAM_LAT - 1);

    state_t              state_q;
    region_t             region_q;
    region_t             region_s;
    logic                is_write_q;
    logic [31:0]         wdata_q;
    logic                armed_q;
    logic [2:0]          wait_cnt_q;
    logic                io_phase_q;
    logic [31:0]         rdata_q;
    logic                mio_ready_q;
    logic                bus_err_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [31:0]         ram_din_q;
    logic [LED_W-1:0]    led_q;
    logic [31:0]         cnt_q;
    logic                req_s;
    logic                accept_s;
    logic [29:0]         word_s;
    logic                unused_s;

    assign req_s    = bus.cpu_mio & (bus.mem_r | bus.mem_w);
    assign accept_s = (state_q == S_IDLE) & armed_q & req_s;
    assign word_s   = bus.addr[31:2];
    assign unused_s = ^bus.addr[1:0];

    // Address decode; IO registers are matched on the full word address.
    always_comb begin
        region_s = R_NONE;
        if (bus.addr[31:28] == 4'h0) begin
            region_s = R_RAM;
        end else if (word_s == 30'h3800_0000) begin
            region_s = R_LED;
        end else if (word_s == 30'h3C00_0000) begin
            region_s = R_SW;
        end else if (word_s == 30'h3C00_0001) begin
            region_s = R_CNT;
        end else begin
            region_s = R_NONE;
        end
    end

    // Free-running cycle counter, wraps at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Access sequencer with all bus and RAM outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            region_q    <= R_NONE;
            is_write_q  <= 1'b0;
            wdata_q     <= 32'd0;
            armed_q     <= 1'b1;
            wait_cnt_q  <= 3'd0;
            io_phase_q  <= 1'b0;
            rdata_q     <= 32'd0;
            mio_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= 32'd0;
            led_q       <= '0;
        end else begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            mio_ready_q <= 1'b0;
            if (!req_s) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        armed_q    <= 1'b0;
                        is_write_q <= bus.mem_w;
                        region_q   <= region_s;
                        wdata_q    <= bus.wdata;
                        if ((bus.mem_r & bus.mem_w) || (region_s == R_NONE)) begin
                            bus_err_q <= 1'b1;
                        end
                        if (region_s == R_RAM) begin
                            state_q    <= S_RAM_REQ;
                            ram_en_q   <= 1'b1;
                            ram_we_q   <= bus.mem_w;
                            ram_addr_q <= bus.addr[ADDR_W+1:2];
                            ram_din_q  <= bus.wdata;
                        end else begin
                            state_q    <= S_IO_ACC;
                            io_phase_q <= 1'b0;
                        end
                    end
                end
                S_RAM_REQ: begin
                    state_q    <= S_RAM_WAIT;
                    wait_cnt_q <= WAIT_INIT;
                end
                // RAM samples ram_en on the edge leaving RAM_REQ; data is valid RAM_LAT-1 edges later.
                S_RAM_WAIT: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q     <= S_DONE;
                        mio_ready_q <= 1'b1;
                        if (!is_write_q) begin
                            rdata_q <= ram_dout;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                S_IO_ACC: begin
                    if (!io_phase_q) begin
                        io_phase_q <= 1'b1;
                        if (is_write_q) begin
                            if (region_q == R_LED) begin
                                led_q <= wdata_q[LED_W-1:0];
                            end
                        end else begin
                            case (region_q)
                                R_LED:   rdata_q <= 32'(led_q);
                                R_SW:    rdata_q <= 32'(sw_in);
                                R_CNT:   rdata_q <= cnt_q;
                                default: rdata_q <= 32'd0;
                            endcase
                        end
                    end else begin
                        state_q     <= S_DONE;
                        mio_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mio_ready = mio_ready_q;
    assign bus.bus_err   = bus_err_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign led_out       = led_q;
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: one DUT with RAM_LAT=1 and one with RAM_LAT=3.
module tb_mio_bus_ctrl;
    logic clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst3_n = 1'b0;
    always #5 clk = ~clk;

    mio_bus_ctrl_if bus1 ();
    mio_bus_ctrl_if bus3 ();

    logic        ram_en1, ram_we1, ram_en3, ram_we3;
    logic [9:0]  ram_addr1, ram_addr3;
    logic [31:0] ram_din1, ram_din3, ram_dout1, ram_dout3;
    logic [15:0] sw_in;
    logic [15:0] led1, led3;

    mio_bus_ctrl #(.ADDR_W(10), .RAM_LAT(1), .LED_W(16)) dut (
        .clk(clk), .reset_n(rst1_n), .bus(bus1.slave),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
        .ram_dout(ram_dout1), .sw_in(sw_in), .led_out(led1)
    );

    mio_bus_ctrl #(.ADDR_W(10), .RAM_LAT(3), .LED_W(16)) dut3 (
        .clk(clk), .reset_n(rst3_n), .bus(bus3.slave),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_din(ram_din3),
        .ram_dout(ram_dout3), .sw_in(sw_in), .led_out(led3)
    );

    // Synchronous RAM models: latency 1 and latency 3.
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] p0, p1, p2;

    always @(posedge clk) begin
        if (ram_en1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_din1;
            ram_dout1 <= mem1[ram_addr1];
        end
    end

    always @(posedge clk) begin
        if (ram_en3) begin
            if (ram_we3) mem3[ram_addr3] <= ram_din3;
            p0 <= mem3[ram_addr3];
        end
        p1 <= p0;
        p2 <= p1;
    end
    assign ram_dout3 = p2;

    int vectors = 0;
    int miscompares = 0;

    int          en_cnt, we_cnt, rdy_cnt, rdy_at;
    logic [9:0]  en_addr;
    logic [15:0] led_hist [0:15];
    logic [31:0] cnt_a, cnt_b;

    task automatic drive(input bit which, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (which) begin
            bus3.mem_r = r; bus3.mem_w = w; bus3.cpu_mio = r | w; bus3.addr = a; bus3.wdata = d;
        end else begin
            bus1.mem_r = r; bus1.mem_w = w; bus1.cpu_mio = r | w; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    // Drive one request at the current negedge, hold it for ncyc cycles, record activity, then drop it.
    task automatic run_access(input bit which, input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int ncyc);
        en_cnt = 0; we_cnt = 0; rdy_cnt = 0; rdy_at = -1; en_addr = 10'd0;
        drive(which, r, w, a, d);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (which ? ram_en3 : ram_en1) begin
                en_cnt++;
                en_addr = which ? ram_addr3 : ram_addr1;
            end
            if (which ? ram_we3 : ram_we1) we_cnt++;
            if (which ? bus3.mio_ready : bus1.mio_ready) begin
                rdy_cnt++;
                if (rdy_at < 0) rdy_at = k;
            end
            if (k < 16) led_hist[k] = which ? led3 : led1;
        end
        drive(which, 1'b0, 1'b0, a, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus1.rdata, bus1.mio_ready, bus1.bus_err, ram_en1, ram_we1} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_bus: got rdata=%h rdy=%b err=%b en=%b we=%b expected all 0",
                     bus1.rdata, bus1.mio_ready, bus1.bus_err, ram_en1, ram_we1);
        end
        vectors++;
        if ({ram_addr1, ram_din1, led1} !== 58'd0) begin
            miscompares++;
            $display("FAIL reset_ram_led: got addr=%h din=%h led=%h expected 0", ram_addr1, ram_din1, led1);
        end
        vectors++;
        if ({bus3.rdata, bus3.mio_ready, bus3.bus_err, ram_en3, led3} !== 51'd0) begin
            miscompares++;
            $display("FAIL reset_dut3: got rdata=%h rdy=%b err=%b en=%b led=%h expected 0",
                     bus3.rdata, bus3.mio_ready, bus3.bus_err, ram_en3, led3);
        end
    endtask

    task automatic test_ram_read_first();
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (ram_en1 !== 1'b1 || ram_we1 !== 1'b0 || ram_addr1 !== 10'd2 || bus1.mio_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL first_req: got en=%b we=%b addr=%0d rdy=%b expected 1 0 2 0",
                     ram_en1, ram_we1, ram_addr1, bus1.mio_ready);
        end
        @(negedge clk);
        vectors++;
        if (ram_en1 !== 1'b0 || bus1.mio_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL first_wait: got en=%b rdy=%b expected 0 0", ram_en1, bus1.mio_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus1.mio_ready !== 1'b1 || bus1.rdata !== 32'h8C01_0004) begin
            miscompares++;
            $display("FAIL first_done: got rdy=%b rdata=%h expected 1 8c010004", bus1.mio_ready, bus1.rdata);
        end
        en_cnt = 0; rdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ram_en1) en_cnt++;
            if (bus1.mio_ready) rdy_cnt++;
        end
        vectors++;
        if (en_cnt != 0 || rdy_cnt != 0) begin
            miscompares++;
            $display("FAIL held_req: got en_cnt=%0d rdy_cnt=%0d expected 0 0", en_cnt, rdy_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_ram_write_read();
        run_access(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_ABCD, 8);
        vectors++;
        if (en_cnt != 1 || we_cnt != 1 || en_addr !== 10'd4 || rdy_cnt != 1 || rdy_at != 3) begin
            miscompares++;
            $display("FAIL ram_write: got en=%0d we=%0d addr=%0d rdy=%0d at=%0d expected 1 1 4 1 3",
                     en_cnt, we_cnt, en_addr, rdy_cnt, rdy_at);
        end
        vectors++;
        if (mem1[4] !== 32'h1234_ABCD || bus1.rdata !== 32'h8C01_0004) begin
            miscompares++;
            $display("FAIL ram_write_data: got mem=%h rdata=%h expected 1234abcd 8c010004", mem1[4], bus1.rdata);
        end
        run_access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 8);
        vectors++;
        if (en_cnt != 1 || we_cnt != 0 || rdy_cnt != 1 || rdy_at != 3 || bus1.rdata !== 32'h1234_ABCD) begin
            miscompares++;
            $display("FAIL ram_readback: got en=%0d we=%0d rdy=%0d at=%0d rdata=%h expected 1 0 1 3 1234abcd",
                     en_cnt, we_cnt, rdy_cnt, rdy_at, bus1.rdata);
        end
    endtask

    task automatic test_led();
        run_access(1'b0, 1'b0, 1'b1, 32'hE000_0000, 32'h0000_00FF, 6);
        vectors++;
        if (led_hist[1] !== 16'h0000 || led_hist[2] !== 16'h00FF || rdy_at != 3 || rdy_cnt != 1 || en_cnt != 0) begin
            miscompares++;
            $display("FAIL led_write: got led1=%h led2=%h at=%0d rdy=%0d en=%0d expected 0000 00ff 3 1 0",
                     led_hist[1], led_hist[2], rdy_at, rdy_cnt, en_cnt);
        end
        run_access(1'b0, 1'b1, 1'b0, 32'hE000_0000, 32'd0, 6);
        vectors++;
        if (bus1.rdata !== 32'h0000_00FF || rdy_at != 3) begin
            miscompares++;
            $display("FAIL led_read: got rdata=%h at=%0d expected 000000ff 3", bus1.rdata, rdy_at);
        end
        run_access(1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_1234, 6);
        vectors++;
        if (led1 !== 16'h00FF || bus1.bus_err !== 1'b0 || rdy_cnt != 1) begin
            miscompares++;
            $display("FAIL sw_write_drop: got led=%h err=%b rdy=%0d expected 00ff 0 1", led1, bus1.bus_err, rdy_cnt);
        end
    endtask

    task automatic test_io_read();
        sw_in = 16'hA5A5;
        run_access(1'b0, 1'b1, 1'b0, 32'hF000_0000, 32'd0, 6);
        vectors++;
        if (bus1.rdata !== 32'h0000_A5A5 || rdy_at != 3) begin
            miscompares++;
            $display("FAIL sw_read: got rdata=%h at=%0d expected 0000a5a5 3", bus1.rdata, rdy_at);
        end
        run_access(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'd0, 9);
        cnt_a = bus1.rdata;
        run_access(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'd0, 9);
        cnt_b = bus1.rdata;
        vectors++;
        if (cnt_b - cnt_a !== 32'd10) begin
            miscompares++;
            $display("FAIL cnt_delta: got %0d expected 10", cnt_b - cnt_a);
        end
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        run_access(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'd0, 9);
        vectors++;
        if (bus1.rdata !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL cnt_wrap: got %h expected 00000000", bus1.rdata);
        end
        run_access(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'd0, 6);
        vectors++;
        if (bus1.rdata !== 32'd10) begin
            miscompares++;
            $display("FAIL cnt_after_wrap: got %h expected 0000000a", bus1.rdata);
        end
    endtask

    task automatic test_unmapped();
        run_access(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'd0, 6);
        vectors++;
        if (bus1.rdata !== 32'd0 || bus1.bus_err !== 1'b1 || rdy_cnt != 1 || rdy_at != 3) begin
            miscompares++;
            $display("FAIL unmapped: got rdata=%h err=%b rdy=%0d at=%0d expected 0 1 1 3",
                     bus1.rdata, bus1.bus_err, rdy_cnt, rdy_at);
        end
        run_access(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 6);
        vectors++;
        if (bus1.bus_err !== 1'b1 || bus1.rdata !== 32'h1234_ABCD) begin
            miscompares++;
            $display("FAIL err_sticky: got err=%b rdata=%h expected 1 1234abcd", bus1.bus_err, bus1.rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        run_access(1'b1, 1'b1, 1'b0, 32'h0000_0018, 32'd0, 8);
        vectors++;
        if (rdy_at != 5 || rdy_cnt != 1 || bus3.rdata !== 32'h0BAD_BEEF) begin
            miscompares++;
            $display("FAIL lat3_read: got at=%0d rdy=%0d rdata=%h expected 5 1 0badbeef", rdy_at, rdy_cnt, bus3.rdata);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'd0);
        repeat (2) @(negedge clk);
        rst3_n = 1'b0;
        #1;
        vectors++;
        if ({bus3.rdata, bus3.mio_ready, ram_en3, ram_we3, ram_addr3} !== 45'd0) begin
            miscompares++;
            $display("FAIL abort_reset: got rdata=%h rdy=%b en=%b we=%b addr=%h expected 0",
                     bus3.rdata, bus3.mio_ready, ram_en3, ram_we3, ram_addr3);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus3.mio_ready) rdy_cnt++;
        end
        vectors++;
        if (rdy_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_no_ready: got %0d pulses expected 0", rdy_cnt);
        end
        run_access(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'd0, 8);
        vectors++;
        if (rdy_at != 5 || rdy_cnt != 1 || en_cnt != 1 || bus3.rdata !== 32'h55AA_1234) begin
            miscompares++;
            $display("FAIL after_abort: got at=%0d rdy=%0d en=%0d rdata=%h expected 5 1 1 55aa1234",
                     rdy_at, rdy_cnt, en_cnt, bus3.rdata);
        end
    endtask

    task automatic test_read_write_conflict();
        vectors++;
        if (bus3.bus_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_pre_err: got %b expected 0", bus3.bus_err);
        end
        run_access(1'b1, 1'b1, 1'b1, 32'h0000_001C, 32'h0000_0077, 8);
        vectors++;
        if (we_cnt != 1 || mem3[7] !== 32'h0000_0077 || bus3.bus_err !== 1'b1 || bus3.rdata !== 32'h55AA_1234) begin
            miscompares++;
            $display("FAIL rw_conflict: got we=%0d mem=%h err=%b rdata=%h expected 1 00000077 1 55aa1234",
                     we_cnt, mem3[7], bus3.bus_err, bus3.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'd0;
            mem3[i] = 32'd0;
        end
        mem1[2] = 32'h8C01_0004;
        mem3[5] = 32'h55AA_1234;
        mem3[6] = 32'h0BAD_BEEF;
        sw_in = 16'h0000;
        test_reset();
        test_ram_read_first();
        test_ram_write_read();
        test_led();
        test_io_read();
        test_unmapped();
        test_reset_mid_access();
        test_read_write_conflict();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
